// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous SRAM controller: state encoding,
// SRAM geometry and default access lengths.
package sram_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam int SRAM_AW    = 18;
  localparam int SRAM_DW    = 16;
  localparam int RD_CYC_DEF = 2;
  localparam int WR_CYC_DEF = 2;
endpackage

// File: rtl/async_sram_ctrl_if.sv
// Request/response bundle between the upstream FSMD (master) and the SRAM
// controller (slave).
interface async_sram_ctrl_if;
  import sram_pkg::*;

  logic               mem;
  logic               rw;
  logic [SRAM_AW-1:0] addr;
  logic [1:0]         be;
  logic [SRAM_DW-1:0] data_f2s;
  logic               ready;
  logic [SRAM_DW-1:0] data_s2f_r;
  logic [SRAM_DW-1:0] data_s2f_ur;

  modport master (output mem, rw, addr, be, data_f2s,
                  input  ready, data_s2f_r, data_s2f_ur);
  modport slave  (input  mem, rw, addr, be, data_f2s,
                  output ready, data_s2f_r, data_s2f_ur);
endinterface

// File: rtl/async_sram_ctrl.sv
// Single-port 256Kx16 async SRAM controller: turns a one-cycle request into
// a registered, glitch-free multi-cycle read or write on the SRAM pins.
module async_sram_ctrl
  import sram_pkg::*;
#(
  parameter int RD_CYC = RD_CYC_DEF,
  parameter int WR_CYC = WR_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  async_sram_ctrl_if.slave   bus,
  output logic [SRAM_AW-1:0] ad,
  output logic               we_n,
  output logic               oe_n,
  inout  wire  [SRAM_DW-1:0] dio_a,
  output logic               ce_a_n,
  output logic               ub_a_n,
  output logic               lb_a_n
);
  localparam int MAXC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [1:0]         be_q, be_d;
  logic [SRAM_DW-1:0] wdata_q, wdata_d;
  logic [SRAM_DW-1:0] rdata_q, rdata_d;
  logic               we_n_q, we_n_d, oe_n_q, oe_n_d, ce_n_q, ce_n_d;
  logic               ub_n_q, ub_n_d, lb_n_q, lb_n_d, tri_en_q, tri_en_d;
  logic               last, ready;

  // The final cycle of an access also accepts the next request, so
  // back-to-back accesses run with no idle gap between them.
  assign last  = ((state_q == ST_RD) && (cnt_q == RD_LAST)) ||
                 ((state_q == ST_WR) && (cnt_q == WR_LAST));
  assign ready = (state_q == ST_IDLE) || last;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    ce_n_d   = ce_n_q;
    ub_n_d   = ub_n_q;
    lb_n_d   = lb_n_q;
    tri_en_d = tri_en_q;

    case (state_q)
      ST_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (last) rdata_d = dio_a;
      end
      ST_WR: begin
        cnt_d  = cnt_q + CW'(1);
        we_n_d = !((cnt_q + CW'(1)) < WR_LAST);
      end
      default: ;
    endcase

    if (last) begin
      state_d  = ST_IDLE;
      we_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      ce_n_d   = 1'b1;
      ub_n_d   = 1'b1;
      lb_n_d   = 1'b1;
      tri_en_d = 1'b0;
    end

    if (ready && bus.mem) begin
      state_d  = bus.rw ? ST_RD : ST_WR;
      cnt_d    = '0;
      addr_d   = bus.addr;
      be_d     = bus.be;
      wdata_d  = bus.data_f2s;
      ce_n_d   = 1'b0;
      ub_n_d   = ~bus.be[1];
      lb_n_d   = ~bus.be[0];
      oe_n_d   = ~bus.rw;
      we_n_d   = bus.rw;
      tri_en_d = ~bus.rw;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      tri_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      ce_n_q   <= ce_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      tri_en_q <= tri_en_d;
    end
  end

  assign dio_a           = tri_en_q ? wdata_q : {SRAM_DW{1'bz}};
  assign ad              = addr_q;
  assign we_n            = we_n_q;
  assign oe_n            = oe_n_q;
  assign ce_a_n          = ce_n_q;
  assign ub_a_n          = ub_n_q;
  assign lb_a_n          = lb_n_q;
  assign bus.ready       = ready;
  assign bus.data_s2f_r  = rdata_q;
  assign bus.data_s2f_ur = dio_a;
endmodule

// File: doc/async_sram_ctrl.md
# async_sram_ctrl

Single-port controller for the 256K×16 asynchronous SRAM (chip A). It sits directly downstream of the SRAM test/user FSMD. It converts a one-cycle `mem`/`rw` request into a multi-cycle SRAM read or write with correct OE/WE/CE sequencing and bus turnaround, and returns the read data both registered and unregistered. It is the only block that drives the SRAM pins.

## Interface
Parameters:
- `RD_CYC`, default 2: number of clocks in a read access (≥2).
- `WR_CYC`, default 2: number of clocks in a write access (≥2). `we_n` is low for the first `WR_CYC-1` of them; the last cycle is the data-hold cycle.

Ports:
- `clk`, in, 1: system clock. All state changes on its rising edge.
- `reset`, in, 1: reset, synchronous and active-low.
- `mem`, in, 1: request strobe. Sampled only while `ready`=1.
- `rw`, in, 1: 1 = read, 0 = write. Sampled with `mem`.
- `addr`, in, 18: word address. Sampled with `mem`.
- `be`, in, 2: byte enables, active-high. [1] = upper byte, [0] = lower byte. Sampled with `mem`.
- `data_f2s`, in, 16: write data. Sampled with `mem`.
- `ready`, out, 1: controller idle, able to accept a request.
- `data_s2f_r`, out, 16: registered read data. Updates at the end of a read.
- `data_s2f_ur`, out, 16: `dio_a` passed straight through, unregistered.
- `ad`, out, 18: SRAM address.
- `we_n`, `oe_n`, out, 1 each: SRAM write enable and output enable.
- `dio_a`, inout, 16: SRAM data bus.
- `ce_a_n`, `ub_a_n`, `lb_a_n`, out, 1 each: chip enable and byte lanes.

## Operation
- States are IDLE, RD, WR, with a wait counter `cnt` of width ceil(log2(max(RD_CYC,WR_CYC)))+1.
- IDLE:
  - `ready`=1.
  - If `mem`=1, latch `addr`, `be`, `data_f2s` and `rw` into registers and clear `cnt`.
  - Go to RD if `rw`=1, otherwise WR.
  - If `mem`=0, stay in IDLE.
- RD:
  - `oe_n`=0, `we_n`=1, bus released (Z).
  - `cnt` increments each clock.
  - When `cnt`=RD_CYC-1, capture `dio_a` into `data_s2f_r` and return to IDLE.
- WR:
  - Bus driven with the latched data for every WR cycle, including the hold cycle.
  - `we_n`=0 while `cnt`<WR_CYC-1, then 1 in the final cycle.
  - `oe_n`=1.
  - At `cnt`=WR_CYC-1, return to IDLE.
- `ad` is the latched address, held constant through the whole access and kept after it.
- `ce_a_n`=0 and `ub_a_n`/`lb_a_n` = ~latched `be` in RD and WR. In IDLE, all three are 1.
- Inputs are ignored outside IDLE. A `mem` asserted in a non-IDLE state is dropped, not queued.
- Back-to-back: a request in the same cycle `ready` returns is accepted, so there are no dead cycles between accesses.
- `be`=2'b00 still runs the full access with both lanes disabled. It is harmless and must not hang.
- All SRAM control outputs and `dio_a` output-enable come from registers, so there are no glitches on the pins.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State → IDLE, `ready`=1, `ad`=0, `data_s2f_r`=0.
  - `we_n`=`oe_n`=`ce_a_n`=`ub_a_n`=`lb_a_n`=1, bus Z.
- Reset mid-access aborts immediately, with pins to their reset values on the next edge. A write cut short this way is undefined in the SRAM and that is acceptable.
- Read latency:
  - Request accepted at edge 0.
  - `oe_n` low from edge 0 to edge RD_CYC.
  - `data_s2f_ur` is valid in the last RD cycle (cycle RD_CYC after acceptance at defaults, i.e. upstream's rd3).
  - `data_s2f_r` is valid and `ready`=1 from edge RD_CYC.
- Write:
  - `we_n` low for WR_CYC-1 clocks.
  - Bus driven from edge 0 to edge WR_CYC.
  - `ready`=1 from edge WR_CYC.
- Throughput is one access per RD_CYC or WR_CYC clocks.
- Bus turnaround: the bus is never driven in a RD cycle, and `oe_n` is never 0 while the bus is driven.

## Structure
- A shared package `sram_pkg` holds:
  - the state encoding for IDLE, RD and WR;
  - constants SRAM_AW=18 and SRAM_DW=16;
  - the default RD_CYC and WR_CYC.
- A single module, with no sub-module. The tri-state is a continuous assign gated by a registered `tri_en`.

## Test plan
- Use an SRAM behavioural model with a 10 ns access time.
- Reset: hold `reset`=0 for 3 clocks → `ready`=1, all `_n` pins =1, bus Z, `data_s2f_r`=0.
- Write then read: write `addr`=18'h00005, `data_f2s`=16'hA5C3, `be`=2'b11, then read the same address → `we_n` low exactly 1 clock; `data_s2f_ur`=A5C3 in cycle 2 of the read; `data_s2f_r`=A5C3 with `ready`=1 after 2 clocks.
- Byte lanes: write 16'hFFFF with `be`=01 to a location holding 16'h0000, then read → 16'h00FF. During the write, `ub_a_n`=1 and `lb_a_n`=0.
- Back-to-back: write addresses 0..3 with data ~addr, holding `mem`=1 continuously → a new access every 2 clocks with no IDLE gaps. A readback of 0..3 returns FFFF, FFFE, FFFD, FFFC.
- Ignored request: pulse `mem` with `rw`=1 in the middle of a write → the write completes unchanged and no read occurs.
- Reset mid-read: assert `reset` in RD cycle 1 → the next edge shows `oe_n`=1, `ce_a_n`=1 and IDLE. `data_s2f_r` is 0.
